// File: rtl/m_dmem_bist_if.sv
// dmem request/response bundle between the BIST master and the memory subsystem.
// Signal names keep their top-level port names so traces line up with the memory-side netlist.
interface m_dmem_bist_if;
  logic        o_dmem_init_done;
  logic [3:0]  o_dmem_init_wen;
  logic [31:0] o_dmem_init_addr;
  logic [31:0] o_dmem_init_data;
  logic        o_dmem_ren;
  logic [3:0]  o_dmem_wen;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_data;
  logic [31:0] i_dmem_data;
  logic        i_dmem_stall;

  modport master (
    output o_dmem_init_done, o_dmem_init_wen, o_dmem_init_addr, o_dmem_init_data,
    output o_dmem_ren, o_dmem_wen, o_dmem_addr, o_dmem_data,
    input  i_dmem_data, i_dmem_stall
  );

  modport slave (
    input  o_dmem_init_done, o_dmem_init_wen, o_dmem_init_addr, o_dmem_init_data,
    input  o_dmem_ren, o_dmem_wen, o_dmem_addr, o_dmem_data,
    output i_dmem_data, i_dmem_stall
  );
endinterface

// File: rtl/m_dmem_bist.sv
// dmem BIST master: init-port fill, read-back, overwrite, second read-back; reports pass/fail.
// Latency 2 cycles/word with no stall; a request is only issued on a cycle where stall is low.
module m_dmem_bist #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 256,
  parameter logic [31:0] SEED      = 32'h1234_5678
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_count,
  output logic [31:0] o_first_err_addr,
  m_dmem_bist_if.master dmem
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FILL_I = 4'd1;
  localparam logic [3:0] S_FILL_W = 4'd2;
  localparam logic [3:0] S_RD1_I  = 4'd3;
  localparam logic [3:0] S_RD1_W  = 4'd4;
  localparam logic [3:0] S_WR2_I  = 4'd5;
  localparam logic [3:0] S_WR2_W  = 4'd6;
  localparam logic [3:0] S_RD2_I  = 4'd7;
  localparam logic [3:0] S_RD2_W  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [15:0] LAST_K  = 16'(NUM_WORDS - 1);
  localparam logic [31:0] BASE_W  = {BASE_ADDR[31:2], 2'b00};

  logic [3:0]  state_q, state_d;
  logic [15:0] k_q, k_d;
  logic [15:0] err_q, err_d;
  logic [31:0] first_q, first_d;
  logic        done_q, done_d;
  logic        init_done_q, init_done_d;
  logic        chk_vld_q, chk_vld_d;
  logic [31:0] chk_dat_q, chk_dat_d;
  logic [31:0] chk_exp_q, chk_exp_d;
  logic [31:0] chk_addr_q, chk_addr_d;

  logic [31:0] addr_w;
  logic [31:0] p1_w;
  logic        stall_w;
  logic        issue_st_w;
  logic        issue_w;
  logic        last_w;

  assign stall_w    = dmem.i_dmem_stall;
  assign addr_w     = BASE_W + {14'd0, k_q, 2'b00};
  assign p1_w       = addr_w ^ SEED;
  assign last_w     = (k_q == LAST_K);
  assign issue_st_w = (state_q == S_FILL_I) || (state_q == S_RD1_I) ||
                      (state_q == S_WR2_I)  || (state_q == S_RD2_I);
  assign issue_w    = issue_st_w && !stall_w;

  // Read data is registered on the response cycle and compared one cycle later;
  // done is delayed by the same cycle so pass/err reflect the final compare.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    err_d       = err_q;
    first_d     = first_q;
    done_d      = done_q;
    init_done_d = init_done_q;
    chk_vld_d   = 1'b0;
    chk_dat_d   = chk_dat_q;
    chk_exp_d   = chk_exp_q;
    chk_addr_d  = chk_addr_q;

    if (chk_vld_q && (chk_dat_q != chk_exp_q)) begin
      if (err_q == 16'd0) first_d = chk_addr_q;
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) done_d = 1'b1;
        if (i_start) begin
          state_d     = S_FILL_I;
          k_d         = 16'd0;
          err_d       = 16'd0;
          first_d     = 32'd0;
          done_d      = 1'b0;
          init_done_d = 1'b0;
        end
      end
      S_FILL_I: if (!stall_w) state_d = S_FILL_W;
      S_RD1_I:  if (!stall_w) state_d = S_RD1_W;
      S_WR2_I:  if (!stall_w) state_d = S_WR2_W;
      S_RD2_I:  if (!stall_w) state_d = S_RD2_W;
      S_FILL_W, S_RD1_W, S_WR2_W, S_RD2_W: begin
        if (!stall_w) begin
          if ((state_q == S_RD1_W) || (state_q == S_RD2_W)) begin
            chk_vld_d  = 1'b1;
            chk_dat_d  = dmem.i_dmem_data;
            chk_exp_d  = (state_q == S_RD1_W) ? p1_w : ~p1_w;
            chk_addr_d = addr_w;
          end
          if (last_w) begin
            k_d = 16'd0;
            case (state_q)
              S_FILL_W: begin
                state_d     = S_RD1_I;
                init_done_d = 1'b1;
              end
              S_RD1_W: state_d = S_WR2_I;
              S_WR2_W: state_d = S_RD2_I;
              default: state_d = S_DONE;
            endcase
          end else begin
            k_d     = k_q + 16'd1;
            state_d = state_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= 16'd0;
      err_q       <= 16'd0;
      first_q     <= 32'd0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
      chk_vld_q   <= 1'b0;
      chk_dat_q   <= 32'd0;
      chk_exp_q   <= 32'd0;
      chk_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      err_q       <= err_d;
      first_q     <= first_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
      chk_vld_q   <= chk_vld_d;
      chk_dat_q   <= chk_dat_d;
      chk_exp_q   <= chk_exp_d;
      chk_addr_q  <= chk_addr_d;
    end
  end

  always_comb begin
    dmem.o_dmem_init_done = init_done_q;
    dmem.o_dmem_init_wen  = 4'b0000;
    dmem.o_dmem_init_addr = 32'd0;
    dmem.o_dmem_init_data = 32'd0;
    dmem.o_dmem_ren       = 1'b0;
    dmem.o_dmem_wen       = 4'b0000;
    dmem.o_dmem_addr      = 32'd0;
    dmem.o_dmem_data      = 32'd0;
    if (issue_w) begin
      case (state_q)
        S_FILL_I: begin
          dmem.o_dmem_init_wen  = 4'b1111;
          dmem.o_dmem_init_addr = addr_w;
          dmem.o_dmem_init_data = p1_w;
        end
        S_WR2_I: begin
          dmem.o_dmem_wen  = 4'b1111;
          dmem.o_dmem_addr = addr_w;
          dmem.o_dmem_data = ~p1_w;
        end
        default: begin
          dmem.o_dmem_ren  = 1'b1;
          dmem.o_dmem_addr = addr_w;
        end
      endcase
    end
  end

  assign o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done           = done_q;
  assign o_pass           = done_q && (err_q == 16'd0);
  assign o_err_count      = err_q;
  assign o_first_err_addr = first_q;

endmodule

// File: tb/tb_m_dmem_bist.sv
// Bench for m_dmem_bist: memory model with optional stalls/corruption plus a request scoreboard.
// Expected request streams and results are computed from the pattern formulas, not read back.
module tb_m_dmem_bist;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          N    = 4;

  typedef struct {
    int          kind;   // 0 init write, 1 read, 2 normal write
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] err;
  logic [31:0] first;

  m_dmem_bist_if dif ();

  m_dmem_bist #(
    .BASE_ADDR(BASE),
    .NUM_WORDS(N),
    .SEED(SEED)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .o_busy(busy),
    .o_done(done),
    .o_pass(pass),
    .o_err_count(err),
    .o_first_err_addr(first),
    .dmem(dif)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  req_t        exp_q[$];
  logic [31:0] mem[logic [31:0]];
  bit          force_stall = 1'b0;
  bit          rand_stall  = 1'b0;
  bit          corrupt     = 1'b0;
  int          n_issue     = 0;
  int          rd108_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue the exact request stream one run must produce.
  task automatic push_run();
    req_t r;
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < N; k++) begin
        r.addr = BASE + 32'(4 * k);
        r.kind = (ph == 0) ? 0 : (ph == 2) ? 2 : 1;
        r.data = (ph == 2) ? ~(r.addr ^ SEED) : (ph == 0) ? (r.addr ^ SEED) : 32'd0;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    n_issue   = 0;
    rd108_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_and_check(input int exp_cyc, input bit hold_mid, input bit exp_pass,
                               input logic [15:0] exp_err, input logic [31:0] exp_first);
    int cyc;
    start_pulse();
    cyc = 0;
    chk("cleared_done", 32'(done), 32'd0);
    chk("cleared_err", 32'(err), 32'd0);
    chk("cleared_first", first, 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start = hold_mid && (cyc >= 5) && (cyc < 15);
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    if (exp_cyc >= 0) chk("done_latency", 32'(cyc), 32'(exp_cyc));
    chk("pass", 32'(pass), 32'(exp_pass));
    chk("err_count", 32'(err), 32'(exp_err));
    chk("first_err_addr", first, exp_first);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("init_done_at_done", 32'(dif.o_dmem_init_done), 32'd1);
    chk("issue_count", 32'(n_issue), 32'(4 * N));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_pass"}, 32'(pass), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
    chk({pfx, "_first"}, first, 32'd0);
    chk({pfx, "_init_done"}, 32'(dif.o_dmem_init_done), 32'd0);
    chk({pfx, "_init_wen"}, 32'(dif.o_dmem_init_wen), 32'd0);
    chk({pfx, "_init_addr"}, dif.o_dmem_init_addr, 32'd0);
    chk({pfx, "_init_data"}, dif.o_dmem_init_data, 32'd0);
    chk({pfx, "_ren"}, 32'(dif.o_dmem_ren), 32'd0);
    chk({pfx, "_wen"}, 32'(dif.o_dmem_wen), 32'd0);
    chk({pfx, "_addr"}, dif.o_dmem_addr, 32'd0);
    chk({pfx, "_data"}, dif.o_dmem_data, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    dif.i_dmem_stall = 1'b0;
    dif.i_dmem_data  = 32'd0;

    fork
      // Memory model: samples requests mid-cycle, responds after optional stall cycles.
      begin : model
        int          kind, delay, stall_cnt;
        bit          issued;
        logic [31:0] addr, wdat, rdat;
        req_t        e;
        stall_cnt = 0;
        delay     = 0;
        rdat      = 32'd0;
        forever begin
          @(negedge clk);
          issued = 1'b0;
          if (!rst && (dif.o_dmem_ren || (|dif.o_dmem_wen) || (|dif.o_dmem_init_wen))) begin
            issued = 1'b1;
            n_issue++;
            chk("no_req_under_stall", 32'(dif.i_dmem_stall), 32'd0);
            kind = (|dif.o_dmem_init_wen) ? 0 : dif.o_dmem_ren ? 1 : 2;
            addr = (kind == 0) ? dif.o_dmem_init_addr : dif.o_dmem_addr;
            wdat = (kind == 0) ? dif.o_dmem_init_data : dif.o_dmem_data;
            chk("init_done_phase", 32'(dif.o_dmem_init_done), (kind == 0) ? 32'd0 : 32'd1);
            if (exp_q.size() == 0) begin
              chk("unexpected_req", addr, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("req_kind", 32'(kind), 32'(e.kind));
              chk("req_addr", addr, e.addr);
              if (kind != 1) chk("req_data", wdat, e.data);
            end
            if (kind != 1) begin
              mem[addr] = wdat;
            end else begin
              rdat = mem.exists(addr) ? mem[addr] : 32'd0;
              if (addr == 32'h108) begin
                if (corrupt && rd108_cnt == 0) rdat = rdat ^ 32'h0000_0001;
                rd108_cnt++;
              end
            end
            delay = rand_stall ? int'($urandom_range(0, 7)) : 0;
          end
          @(posedge clk); #1;
          if (rst) stall_cnt = 0;
          else if (issued) begin
            stall_cnt       = delay;
            dif.i_dmem_data = rdat;
          end else if (stall_cnt > 0) stall_cnt--;
          dif.i_dmem_stall = force_stall || (stall_cnt > 0);
        end
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Zero-stall run with latency check
    run_and_check(8 * N + 1, 1'b0, 1'b1, 16'd0, 32'd0);

    // Stall held high for 100 cycles from reset, start at cycle 5
    force_stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      begin
        repeat (100) @(posedge clk);
        #1;
        chk("no_issue_while_stalled", 32'(n_issue), 32'd0);
        chk("busy_while_stalled", 32'(busy), 32'd1);
        force_stall = 1'b0;
      end
    join_none
    repeat (3) @(posedge clk);
    run_and_check(-1, 1'b0, 1'b1, 16'd0, 32'd0);

    // Random stalls after every issue
    rand_stall = 1'b1;
    run_and_check(-1, 1'b0, 1'b1, 16'd0, 32'd0);
    rand_stall = 1'b0;

    // Corrupted RD1 read of 0x108
    corrupt = 1'b1;
    run_and_check(-1, 1'b0, 1'b0, 16'd1, 32'h0000_0108);
    corrupt = 1'b0;

    // Restart from DONE with start held mid-run: errors cleared, same traffic
    rand_stall = 1'b1;
    run_and_check(-1, 1'b1, 1'b1, 16'd0, 32'd0);
    rand_stall = 1'b0;

    // Reset during RD1_W aborts at once
    start_pulse();
    for (int g = 0; g < 200 && n_issue < N + 1; g++) @(posedge clk);
    chk("reached_rd1", 32'(n_issue), 32'(N + 1));
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("abort");
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_abort_busy", 32'(busy), 32'd0);
    chk("idle_after_abort_ren", 32'(dif.o_dmem_ren), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
